// File: rtl/srmem_rd_arbiter.sv
// srmem_rd_arbiter: round-robin read-side scheduler sharing one srmem among NUM_REQ consumers
module srmem_rd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int QUANTUM = 8,
  parameter int TIMEOUT = 64,
  localparam int IW = $clog2(NUM_REQ),
  localparam int PW = $clog2(QUANTUM + 1),
  localparam int TW = $clog2(TIMEOUT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] pop,
  input  logic               rdvalid,
  input  logic               rdlast,
  input  logic               rdend,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_id,
  output logic               req_pop,
  output logic               req_newdata,
  output logic               busy,
  output logic               err_timeout
);
  typedef enum logic [1:0] {IDLE, SERVE, RELOAD, WAIT_NEW} state_e;
  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      gid_q, gid_d, rr_q, rr_d, win, gid_nxt;
  logic [PW-1:0]      pc_q, pc_d, pc_nxt;
  logic [TW-1:0]      to_q, to_d;
  logic               err_q, err_d, others;
  // cyclic search: lowest offset from rr_q with a pending request wins
  always_comb begin
    win = rr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[IW'((int'(rr_q) + k) % NUM_REQ)]) win = IW'((int'(rr_q) + k) % NUM_REQ);
    end
  end
  assign gid_nxt = (gid_q == IW'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
  assign others  = |(req & ~grant_q);
  assign pc_nxt  = (req_pop && pc_q != PW'(QUANTUM)) ? pc_q + 1'b1 : pc_q;
  // next-state and strobes; strobes are masked during reset so an aborted grant or reload emits nothing
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gid_d       = gid_q;
    rr_d        = rr_q;
    pc_d        = pc_q;
    to_d        = to_q;
    err_d       = err_q;
    req_pop     = 1'b0;
    req_newdata = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req && rdvalid) begin
          state_d = SERVE;
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
          gid_d   = win;
          pc_d    = '0;
        end else if (|req && rdend) begin
          state_d = RELOAD;
        end
      end
      SERVE: begin
        req_pop = pop[gid_q] & rdvalid & ~rst;
        pc_d    = pc_nxt;
        if ((req_pop && rdlast) || !req[gid_q] || (pc_nxt == PW'(QUANTUM) && others)) begin
          state_d = (req_pop && rdlast) ? RELOAD : IDLE;
          grant_d = '0;
          rr_d    = gid_nxt;
        end else if (pc_nxt == PW'(QUANTUM)) begin
          pc_d = '0;
        end
      end
      RELOAD: begin
        req_newdata = ~rst;
        to_d        = '0;
        state_d     = WAIT_NEW;
      end
      default: begin
        to_d = to_q + 1'b1;
        if (rdvalid && !rdend) begin
          state_d = IDLE;
        end else if (to_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gid_q   <= '0;
      rr_q    <= '0;
      pc_q    <= '0;
      to_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      pc_q    <= pc_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end
  assign grant       = grant_q;
  assign grant_id    = gid_q;
  assign busy        = state_q != IDLE;
  assign err_timeout = err_q;
endmodule

// File: tb/tb_srmem_rd_arbiter.sv
// tb_srmem_rd_arbiter: directed stimulus with a scoreboard of expected grant/pop/newdata events
module tb_srmem_rd_arbiter;
  logic       clk = 1'b0;
  logic       rst, rdvalid, rdlast, rdend;
  logic [3:0] req, pop, grant;
  logic [1:0] grant_id;
  logic       req_pop, req_newdata, busy, err_timeout;
  logic [3:0] prev_grant = '0;
  logic [5:0] exp_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  localparam logic [1:0] GR = 2'd1, PP = 2'd2, ND = 2'd3;

  srmem_rd_arbiter #(.NUM_REQ(4), .QUANTUM(8), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req(req), .pop(pop), .rdvalid(rdvalid), .rdlast(rdlast),
    .rdend(rdend), .grant(grant), .grant_id(grant_id), .req_pop(req_pop),
    .req_newdata(req_newdata), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic exp_ev(input logic [1:0] kind, input logic [3:0] data);
    exp_q.push_back({kind, data});
  endtask

  task automatic sb_check(input logic [5:0] got);
    logic [5:0] want;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: unexpected event %0h, expected none", got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        n_fail++;
        $display("FAIL scoreboard: event %0h, expected %0h", got, want);
      end
    end
  endtask

  // monitor: turns DUT output activity into events compared against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (grant != 4'd0 && grant != prev_grant) sb_check({GR, grant});
      if (req_pop) sb_check({PP, 2'b00, grant_id});
      if (req_newdata) sb_check({ND, 4'd0});
    end
    prev_grant = rst ? 4'd0 : grant;
  end

  initial begin
    rst = 1'b1; req = 4'hF; pop = 4'hF; rdvalid = 1'b0; rdlast = 1'b0; rdend = 1'b0;
    repeat (2) cyc();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_req_pop", 32'(req_pop), 32'd0);
    chk("rst_newdata", 32'(req_newdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    rst = 1'b0; req = 4'b1010; pop = 4'd0; rdvalid = 1'b1;
    exp_ev(GR, 4'b0010);
    cyc();
    pop = 4'b0010;
    repeat (3) exp_ev(PP, 4'd1);
    cyc();
    cyc();
    rdlast = 1'b1;
    cyc();
    pop = 4'd0; rdlast = 1'b0; rdvalid = 1'b0; rdend = 1'b1;
    exp_ev(ND, 4'd0);
    cyc();
    chk("wait_busy", 32'(busy), 32'd1);
    cyc();
    rdvalid = 1'b1; rdend = 1'b0;
    cyc();
    exp_ev(GR, 4'b1000);
    cyc();
    req = 4'b0010;
    cyc();
    req = 4'b1010;
    exp_ev(GR, 4'b0010);
    cyc();
    req = 4'b0001;
    cyc();
    req = 4'b0011;
    exp_ev(GR, 4'b0001);
    cyc();
    pop = 4'b0001;
    repeat (8) begin
      exp_ev(PP, 4'd0);
      cyc();
    end
    chk("quantum_preempt", 32'(grant), 32'd0);
    pop = 4'd0;
    exp_ev(GR, 4'b0010);
    cyc();
    req = 4'b0001;
    cyc();
    exp_ev(GR, 4'b0001);
    cyc();
    pop = 4'b0001;
    repeat (10) begin
      exp_ev(PP, 4'd0);
      cyc();
    end
    chk("quantum_hold", 32'(grant), 32'b0001);
    pop = 4'd0; req = 4'b0100;
    cyc();
    exp_ev(GR, 4'b0100);
    cyc();
    req = 4'd0; pop = 4'b0100;
    exp_ev(PP, 4'd2);
    #1 chk("release_pop", 32'(req_pop), 32'd1);
    cyc();
    chk("release_grant", 32'(grant), 32'd0);
    pop = 4'd0; req = 4'b0001;
    exp_ev(GR, 4'b0001);
    cyc();
    pop = 4'b1000;
    #1 chk("ign_other", 32'(req_pop), 32'd0);
    cyc();
    pop = 4'b0001; rdvalid = 1'b0;
    #1 chk("ign_invalid", 32'(req_pop), 32'd0);
    cyc();
    rdvalid = 1'b1; rdlast = 1'b1;
    exp_ev(PP, 4'd0);
    cyc();
    pop = 4'd0; rdlast = 1'b0; rdvalid = 1'b0; rdend = 1'b1; req = 4'd0;
    exp_ev(ND, 4'd0);
    cyc();
    repeat (63) cyc();
    chk("to_before_err", 32'(err_timeout), 32'd0);
    chk("to_before_busy", 32'(busy), 32'd1);
    cyc();
    chk("to_err", 32'(err_timeout), 32'd1);
    chk("to_idle", 32'(busy), 32'd0);
    repeat (5) cyc();
    chk("to_sticky", 32'(err_timeout), 32'd1);
    rst = 1'b1;
    cyc();
    chk("to_rst_clear", 32'(err_timeout), 32'd0);
    rst = 1'b0;
    repeat (2) cyc();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
